// File: rtl/io_pkg.sv
// Shared IO definitions: debounce FSM states and default debounce length.
package io_pkg;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        HELD         = 2'd2,
        RELEASE_WAIT = 2'd3
    } deb_state_e;

    // About 0.4 ms at a 50 MHz CPU clock.
    localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = 20000;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous level inputs, cleared to zero on reset.
module sync_2ff #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    // Two back-to-back flops; the output lags the input by exactly two edges.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/switch_input_conditioner.sv
// Board switch/enter-button front end: synchronizes raw inputs, debounces the
// enter button and captures a switch snapshot on each accepted press.
module switch_input_conditioner
    import io_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter int unsigned CNT_W           = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] switch_raw,
    input  logic        enter_raw,
    input  logic        ack,
    output logic [15:0] switch_data,
    output logic        enter_pulse,
    output logic        data_valid,
    output logic        overrun
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [15:0]      switch_sync;
    logic             enter_sync;

    deb_state_e       state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             accept;

    logic [15:0]      switch_data_q, switch_data_d;
    logic             enter_pulse_q, enter_pulse_d;
    logic             data_valid_q, data_valid_d;
    logic             overrun_q, overrun_d;

    sync_2ff #(.WIDTH(16)) u_sync_switch (
        .clk_i (clk),
        .rst_i (reset),
        .d_i   (switch_raw),
        .q_o   (switch_sync)
    );

    sync_2ff #(.WIDTH(1)) u_sync_enter (
        .clk_i (clk),
        .rst_i (reset),
        .d_i   (enter_raw),
        .q_o   (enter_sync)
    );

    // Debounce state, counter and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            count_q       <= '0;
            switch_data_q <= '0;
            enter_pulse_q <= 1'b0;
            data_valid_q  <= 1'b0;
            overrun_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            count_q       <= count_d;
            switch_data_q <= switch_data_d;
            enter_pulse_q <= enter_pulse_d;
            data_valid_q  <= data_valid_d;
            overrun_q     <= overrun_d;
        end
    end

    // Next-state logic: a press is accepted only on the PRESS_WAIT->HELD edge.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        accept  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (enter_sync) begin
                    state_d = PRESS_WAIT;
                    count_d = '0;
                end
            end
            PRESS_WAIT: begin
                if (!enter_sync) begin
                    state_d = IDLE;
                end else if (count_q == CNT_LAST) begin
                    state_d = HELD;
                    accept  = 1'b1;
                end else begin
                    count_d = count_q + CNT_W'(1);
                end
            end
            HELD: begin
                if (!enter_sync) begin
                    state_d = RELEASE_WAIT;
                    count_d = '0;
                end
            end
            RELEASE_WAIT: begin
                if (enter_sync) begin
                    state_d = HELD;
                end else if (count_q == CNT_LAST) begin
                    state_d = IDLE;
                end else begin
                    count_d = count_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Capture, valid/ack handshake and sticky overrun; a new press wins over ack.
    always_comb begin
        enter_pulse_d = accept;
        switch_data_d = accept ? switch_sync : switch_data_q;
        data_valid_d  = data_valid_q;
        if (accept) begin
            data_valid_d = 1'b1;
        end else if (ack) begin
            data_valid_d = 1'b0;
        end
        overrun_d = overrun_q | (accept & data_valid_q & ~ack);
    end

    assign switch_data = switch_data_q;
    assign enter_pulse = enter_pulse_q;
    assign data_valid  = data_valid_q;
    assign overrun     = overrun_q;

endmodule

// File: tb/tb_switch_input_conditioner.sv
// Directed bench for switch_input_conditioner with a snapshot scoreboard.
`timescale 1ns/1ps
module tb_switch_input_conditioner;
    import io_pkg::*;

    localparam int unsigned DEB = 4;
    localparam int LAT = DEB + 3;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] switch_raw;
    logic        enter_raw;
    logic        ack;
    logic [15:0] switch_data;
    logic        enter_pulse;
    logic        data_valid;
    logic        overrun;

    int n_cmp = 0;
    int n_err = 0;
    int n_pulse = 0;
    int exp_pulses = 0;
    logic [15:0] sb[$];

    switch_input_conditioner #(
        .DEBOUNCE_CYCLES (DEB),
        .CNT_W           (16)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .switch_raw  (switch_raw),
        .enter_raw   (enter_raw),
        .ack         (ack),
        .switch_data (switch_data),
        .enter_pulse (enter_pulse),
        .data_valid  (data_valid),
        .overrun     (overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_pulse(input int max_edges, output int edges);
        edges = 0;
        do begin
            @(posedge clk);
            #1;
            edges++;
        end while (!enter_pulse && edges < max_edges);
    endtask

    task automatic press(input logic [15:0] sw);
        switch_raw = sw;
        sb.push_back(sw);
        exp_pulses++;
        enter_raw = 1'b1;
    endtask

    // Scoreboard: every pulse must match the next expected snapshot.
    always @(negedge clk) begin
        if (enter_pulse) begin
            n_pulse++;
            check("pulse_expected", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                logic [15:0] ev;
                ev = sb.pop_front();
                check("sb_switch_data", 32'(switch_data), 32'(ev));
            end
        end
    end

    initial begin
        int e;
        reset      = 1'b1;
        switch_raw = '0;
        enter_raw  = 1'b0;
        ack        = 1'b0;
        #2;
        check("rst_switch_data", 32'(switch_data), 32'h0);
        check("rst_pulse", 32'(enter_pulse), 32'd0);
        check("rst_valid", 32'(data_valid), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
        check("rst_state", 32'(dut.state_q), 32'(IDLE));
        step(2);
        reset = 1'b0;
        step(1);

        // Basic press latency and capture
        press(16'hA55A);
        wait_pulse(50, e);
        check("press_latency", 32'(e), 32'(LAT));
        check("press_valid", 32'(data_valid), 32'd1);
        check("press_data", 32'(switch_data), 32'hA55A);
        step(1);
        check("pulse_one_cycle", 32'(enter_pulse), 32'd0);
        switch_raw = 16'hFFFF;
        step(10);
        check("data_stable", 32'(switch_data), 32'hA55A);
        check("held_state", 32'(dut.state_q), 32'(HELD));
        check("held_no_pulse", 32'(n_pulse), 32'(exp_pulses));

        // Ack clears valid; a second ack is ignored
        ack = 1'b1;
        step(1);
        ack = 1'b0;
        check("ack_clear", 32'(data_valid), 32'd0);
        ack = 1'b1;
        step(1);
        ack = 1'b0;
        check("ack2_valid", 32'(data_valid), 32'd0);
        check("ack2_overrun", 32'(overrun), 32'd0);
        check("ack2_data", 32'(switch_data), 32'hA55A);
        enter_raw = 1'b0;
        step(12);
        check("release_idle", 32'(dut.state_q), 32'(IDLE));

        // Bouncing button: toggling every 2 cycles never qualifies
        for (int i = 0; i < 20; i++) begin
            enter_raw = ~enter_raw;
            step(2);
        end
        enter_raw = 1'b0;
        step(10);
        check("bounce_idle", 32'(dut.state_q), 32'(IDLE));
        check("bounce_valid", 32'(data_valid), 32'd0);
        check("bounce_no_pulse", 32'(n_pulse), 32'(exp_pulses));

        // Release bounce in HELD returns to HELD without a pulse
        press(16'h1234);
        wait_pulse(50, e);
        check("press2_latency", 32'(e), 32'(LAT));
        ack = 1'b1;
        step(1);
        ack = 1'b0;
        enter_raw = 1'b0;
        step(2);
        enter_raw = 1'b1;
        step(15);
        check("relbounce_state", 32'(dut.state_q), 32'(HELD));
        check("relbounce_no_pulse", 32'(n_pulse), 32'(exp_pulses));
        check("relbounce_valid", 32'(data_valid), 32'd0);
        enter_raw = 1'b0;
        step(12);

        // Two presses without ack: overwrite and sticky overrun
        press(16'h0001);
        wait_pulse(50, e);
        check("ovr1_latency", 32'(e), 32'(LAT));
        check("ovr1_overrun", 32'(overrun), 32'd0);
        enter_raw = 1'b0;
        step(12);
        press(16'h0002);
        wait_pulse(50, e);
        check("ovr2_latency", 32'(e), 32'(LAT));
        check("ovr2_data", 32'(switch_data), 32'h0002);
        check("ovr2_valid", 32'(data_valid), 32'd1);
        check("ovr2_overrun", 32'(overrun), 32'd1);
        enter_raw = 1'b0;
        step(12);
        ack = 1'b1;
        step(1);
        ack = 1'b0;
        step(5);
        check("ovr_sticky", 32'(overrun), 32'd1);
        check("ovr_ack_valid", 32'(data_valid), 32'd0);

        // Reset during PRESS_WAIT with the button held
        switch_raw = 16'h00C3;
        enter_raw  = 1'b1;
        step(3);
        check("pw_state", 32'(dut.state_q), 32'(PRESS_WAIT));
        #2 reset = 1'b1;
        #1;
        check("async_rst_data", 32'(switch_data), 32'h0);
        check("async_rst_valid", 32'(data_valid), 32'd0);
        check("async_rst_overrun", 32'(overrun), 32'd0);
        check("async_rst_state", 32'(dut.state_q), 32'(IDLE));
        step(1);
        #3 reset = 1'b0;
        sb.push_back(16'h00C3);
        exp_pulses++;
        wait_pulse(50, e);
        check("rst_requal_latency", 32'(e), 32'(LAT));
        check("rst_requal_data", 32'(switch_data), 32'h00C3);
        check("rst_requal_valid", 32'(data_valid), 32'd1);
        step(8);
        check("total_pulses", 32'(n_pulse), 32'(exp_pulses));
        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
